rect_move_ctl: RTL and testbench
================================

Name: rect_move_ctl

Overview:
- Consumer of the four debounced direction levels (rect_up, rect_down, rect_left, rect_right) produced by the pushbutton debounce stage.
- Turns button presses into rectangle position updates:
  - one step on each press;
  - auto-repeat while the button is held, timed in frames.
- Drives xpos/ypos into the rectangle draw stage of the 1024x768 VGA pipeline.
- Position stays clamped to the visible area.

Parameters:
- H_RES, 1024, horizontal visible pixels
- V_RES, 768, vertical visible lines
- RECT_W, 48, rectangle width in pixels
- RECT_H, 64, rectangle height in lines
- STEP, 4, pixels moved per step; must be 1..RECT_W
- X_INIT, 488, xpos after reset
- Y_INIT, 352, ypos after reset
- DLY_FR, 20, frame_tick pulses from the press step to the first repeat step
- PER_FR, 4, frame_tick pulses between repeat steps; must be >= 1

Ports:
- clk_in  in  1  pixel clock (65 MHz); the only clock
- rst_n  in  1  asynchronous active-low reset
- rect_up  in  1  debounced level, clk_in domain, 1 = pressed
- rect_down  in  1  debounced level, 1 = pressed
- rect_left  in  1  debounced level, 1 = pressed
- rect_right  in  1  debounced level, 1 = pressed
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- xpos  out  12  rectangle left edge, 0..H_RES-RECT_W
- ypos  out  12  rectangle top edge, 0..V_RES-RECT_H
- at_edge  out  1  1 while either coordinate sits on a limit

Behaviour:
- Reset is asynchronous, active-low, and applies to all flops:
  - xpos=X_INIT, ypos=Y_INIT, at_edge=0;
  - axis FSMs go to IDLE, frame counters clear;
  - the input sample registers clear to 0.
- Reset asserted mid-hold: the button is treated as released. If it is still high after reset, that counts as a new press.
- Axis command: each axis sees a signed direction.
  - x axis: right alone = +1, left alone = -1; both or neither = 0.
  - y axis: down alone = +1, up alone = -1; both or neither = 0.
  - Axes are independent, so diagonal movement is allowed.
- Each axis has a registered previous direction, dir_q.
- Per-axis FSM:
  - IDLE: if dir != 0, apply one step and go to HOLD with the frame counter at 0.
  - HOLD: count frame_tick pulses. When the count reaches DLY_FR, apply a step, clear the count, go to RPT.
  - RPT: count frame_tick pulses. When the count reaches PER_FR, apply a step and clear the count.
- Leaving HOLD/RPT:
  - dir==0 in HOLD or RPT: go to IDLE with no step.
  - dir != dir_q with dir != 0 (direction reversal): step in the new direction, go to HOLD, counter to 0. A reversal counts as a fresh press.
- Latency:
  - A press is sampled at clock edge k and the position register updates at edge k.
  - The new xpos/ypos is visible from the cycle after the first high sample.
  - A frame_tick that completes a count gives a position update visible the next cycle.
- Arithmetic:
  - Computed at 13 bits signed: pos ± STEP.
  - If the result is < 0, clamp to 0. If it is > LIMIT, clamp to LIMIT, where LIMIT is H_RES-RECT_W for x and V_RES-RECT_H for y.
  - Stepping into a limit while already at it leaves the position unchanged. The FSM still advances.
- at_edge is registered. It is 1 when xpos is 0 or LIMIT_X, or ypos is 0 or LIMIT_Y, and is evaluated on the updated values.
- A press and a frame_tick in the same cycle from IDLE: only the press step is applied. The frame_tick is not counted.

Optional Feature:
- Macro: RECT_MOVE_WRAP_EN
- Defined: the clamp is replaced by wrap.
  - Result < 0 becomes result + LIMIT + 1.
  - Result > LIMIT becomes result - LIMIT - 1.
  - at_edge is tied to 0.
- Undefined: saturating clamp as above.

Decomposition:
- Package rect_pkg:
  - H_RES/V_RES/RECT_W/RECT_H defaults;
  - POS_W=12;
  - the axis state enum {AX_IDLE, AX_HOLD, AX_RPT};
  - the signed direction type.
- Sub-module rect_axis_ctl, instantiated twice, with parameters LIMIT, INIT, STEP, DLY_FR, PER_FR.
  - Inputs: neg, pos, frame_tick.
  - Output: pos_out.
  - Contains the FSM, frame counter, clamp/wrap, and dir_q.
- The top level holds the two instances plus the at_edge register.

Test Plan:
- Reset, then hold all inputs 0 for 10 frames -> xpos=488, ypos=352, at_edge=0 throughout.
- rect_right pulsed high for 3 cycles with no frame_tick -> xpos=492 the cycle after the first high sample; no further change.
- rect_right held for 30 frames with DLY_FR=20, PER_FR=4 -> steps at press, at tick 20, at tick 24, at tick 28; xpos ends at 504.
- rect_left and rect_right both held 30 frames -> xpos stays 488. Releasing right -> xpos steps to 484 immediately.
- From xpos=4, press left twice -> 0 then 0, with at_edge=1. Repeat with RECT_MOVE_WRAP_EN defined -> 0 then 973.
- Hold rect_down, assert rst_n=0 mid-RPT, release reset with down still high -> ypos=352 during reset, then 356 the cycle after the first post-reset sample.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared types and defaults for the rectangle move controller.
// Display geometry, position width, axis FSM states and the signed direction type.
package rect_pkg;

  localparam int unsigned H_RES  = 1024;
  localparam int unsigned V_RES  = 768;
  localparam int unsigned RECT_W = 48;
  localparam int unsigned RECT_H = 64;
  localparam int unsigned POS_W  = 12;

  typedef enum logic [1:0] {
    AX_IDLE,
    AX_HOLD,
    AX_RPT
  } ax_state_e;

  // -1, 0 or +1 along one axis
  typedef logic signed [1:0] dir_t;

  // Opposing buttons cancel; a lone button gives its sign.
  function automatic dir_t dir_of(input logic neg, input logic pos);
    dir_t d;
    case ({pos, neg})
      2'b10:   d = 2'sb01;
      2'b01:   d = 2'sb11;
      default: d = 2'sb00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rect_move_ctl_if.sv
// Button/frame inputs and rectangle position outputs of rect_move_ctl.
// master drives buttons and frame_tick; slave is the controller.
interface rect_move_ctl_if;

  logic                      rect_up;
  logic                      rect_down;
  logic                      rect_left;
  logic                      rect_right;
  logic                      frame_tick;
  logic [rect_pkg::POS_W-1:0] xpos;
  logic [rect_pkg::POS_W-1:0] ypos;
  logic                      at_edge;

  modport master (
    output rect_up, rect_down, rect_left, rect_right, frame_tick,
    input  xpos, ypos, at_edge
  );

  modport slave (
    input  rect_up, rect_down, rect_left, rect_right, frame_tick,
    output xpos, ypos, at_edge
  );

endinterface

// File: rtl/rect_axis_ctl.sv
// One movement axis: press step, frame-timed auto-repeat, clamp (or wrap
// when RECT_MOVE_WRAP_EN is defined) to 0..LIMIT.
module rect_axis_ctl
  import rect_pkg::*;
#(
  parameter int unsigned LIMIT  = 976,
  parameter int unsigned INIT   = 488,
  parameter int unsigned STEP   = 4,
  parameter int unsigned DLY_FR = 20,
  parameter int unsigned PER_FR = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             neg,
  input  logic             pos,
  input  logic             frame_tick,
  output logic [POS_W-1:0] pos_out,
  output logic [POS_W-1:0] pos_nxt_c
);

  localparam int unsigned SUM_W   = POS_W + 1;
  localparam int unsigned CNT_MAX = (DLY_FR > PER_FR) ? DLY_FR : PER_FR;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [SUM_W-1:0] STEP_S  = SUM_W'(STEP);
  localparam logic signed [SUM_W-1:0] LIMIT_S = SUM_W'(LIMIT);
`ifdef RECT_MOVE_WRAP_EN
  localparam logic signed [SUM_W-1:0] WRAP_S  = SUM_W'(LIMIT + 1);
`endif

  ax_state_e               state_q, state_d;
  dir_t                    dir_q, dir_d;
  dir_t                    dir_c;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc_c, cnt_tgt_c;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic signed [SUM_W-1:0] sum_c;
  logic [POS_W-1:0]        step_pos_c;
  logic                    do_step_c;

  assign dir_c = dir_of(neg, pos);

  // Candidate position one step along dir_c, limited to the visible range
  always_comb begin
    sum_c      = $signed({1'b0, pos_q}) + (dir_c[1] ? -STEP_S : STEP_S);
    step_pos_c = sum_c[POS_W-1:0];
`ifdef RECT_MOVE_WRAP_EN
    if (sum_c < 0) begin
      step_pos_c = POS_W'(sum_c + WRAP_S);
    end else if (sum_c > LIMIT_S) begin
      step_pos_c = POS_W'(sum_c - WRAP_S);
    end
`else
    if (sum_c < 0) begin
      step_pos_c = '0;
    end else if (sum_c > LIMIT_S) begin
      step_pos_c = POS_W'(LIMIT);
    end
`endif
  end

  // Axis FSM: fresh press or reversal steps at once, then DLY_FR / PER_FR frames
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_c;
    do_step_c = 1'b0;
    cnt_inc_c = cnt_q + CNT_W'(1);
    cnt_tgt_c = (state_q == AX_HOLD) ? CNT_W'(DLY_FR) : CNT_W'(PER_FR);

    case (state_q)
      AX_IDLE: begin
        if (dir_c != 2'sb00) begin
          do_step_c = 1'b1;
          state_d   = AX_HOLD;
          cnt_d     = '0;
        end
      end
      AX_HOLD, AX_RPT: begin
        if (dir_c == 2'sb00) begin
          state_d = AX_IDLE;
          cnt_d   = '0;
        end else if (dir_c != dir_q) begin
          do_step_c = 1'b1;
          state_d   = AX_HOLD;
          cnt_d     = '0;
        end else if (frame_tick) begin
          if (cnt_inc_c == cnt_tgt_c) begin
            do_step_c = 1'b1;
            state_d   = AX_RPT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      default: begin
        state_d = AX_IDLE;
        cnt_d   = '0;
      end
    endcase

    pos_d = do_step_c ? step_pos_c : pos_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AX_IDLE;
      cnt_q   <= '0;
      dir_q   <= 2'sb00;
      pos_q   <= POS_W'(INIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  assign pos_out   = pos_q;
  assign pos_nxt_c = pos_d;

endmodule

// File: rtl/rect_move_ctl.sv
// Rectangle position controller: two independent axis controllers plus the
// registered at_edge flag. RECT_MOVE_WRAP_EN selects wrap instead of clamp.
module rect_move_ctl
  import rect_pkg::POS_W;
#(
  parameter int unsigned H_RES  = rect_pkg::H_RES,
  parameter int unsigned V_RES  = rect_pkg::V_RES,
  parameter int unsigned RECT_W = rect_pkg::RECT_W,
  parameter int unsigned RECT_H = rect_pkg::RECT_H,
  parameter int unsigned STEP   = 4,
  parameter int unsigned X_INIT = 488,
  parameter int unsigned Y_INIT = 352,
  parameter int unsigned DLY_FR = 20,
  parameter int unsigned PER_FR = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  rect_move_ctl_if.slave        bus
);

  localparam int unsigned LIMIT_X = H_RES - RECT_W;
  localparam int unsigned LIMIT_Y = V_RES - RECT_H;

  logic [POS_W-1:0] x_pos, y_pos;
  logic [POS_W-1:0] x_nxt_c, y_nxt_c;
  logic             at_edge_q, at_edge_d;

  rect_axis_ctl #(
    .LIMIT (LIMIT_X),
    .INIT  (X_INIT),
    .STEP  (STEP),
    .DLY_FR(DLY_FR),
    .PER_FR(PER_FR)
  ) u_x_axis (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .neg       (bus.rect_left),
    .pos       (bus.rect_right),
    .frame_tick(bus.frame_tick),
    .pos_out   (x_pos),
    .pos_nxt_c (x_nxt_c)
  );

  rect_axis_ctl #(
    .LIMIT (LIMIT_Y),
    .INIT  (Y_INIT),
    .STEP  (STEP),
    .DLY_FR(DLY_FR),
    .PER_FR(PER_FR)
  ) u_y_axis (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .neg       (bus.rect_up),
    .pos       (bus.rect_down),
    .frame_tick(bus.frame_tick),
    .pos_out   (y_pos),
    .pos_nxt_c (y_nxt_c)
  );

  // Edge flag follows the positions being loaded this cycle
  always_comb begin
`ifdef RECT_MOVE_WRAP_EN
    at_edge_d = 1'b0;
`else
    at_edge_d = (x_nxt_c == '0) || (x_nxt_c == POS_W'(LIMIT_X)) ||
                (y_nxt_c == '0) || (y_nxt_c == POS_W'(LIMIT_Y));
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      at_edge_q <= 1'b0;
    end else begin
      at_edge_q <= at_edge_d;
    end
  end

  assign bus.xpos    = x_pos;
  assign bus.ypos    = y_pos;
  assign bus.at_edge = at_edge_q;

endmodule

// File: tb/tb_rect_move_ctl.sv
// Self-checking bench for rect_move_ctl: directed scenarios with literal
// expectations plus randomized button/frame stimulus against a reference model.
module tb_rect_move_ctl;

  localparam int STEP   = 4;
  localparam int DLY_FR = 20;
  localparam int PER_FR = 4;
  localparam int LIM_X  = 1024 - 48;
  localparam int LIM_Y  = 768 - 64;
  localparam int X0     = 488;
  localparam int Y0     = 352;
`ifdef RECT_MOVE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rect_move_ctl_if bus ();

  rect_move_ctl dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a step happens on a new nonzero direction, or after
  // DLY_FR ticks (first repeat) / PER_FR ticks (later repeats) of holding it.
  int m_pos[2];
  int m_prev[2];
  int m_ticks[2];
  bit m_rep[2];
  bit m_edge;

  function automatic int mv(input int p, input int d, input int lim);
    int r;
    r = p + d * STEP;
    if (WRAP) begin
      if (r < 0) r = r + lim + 1;
      else if (r > lim) r = r - lim - 1;
    end else begin
      if (r < 0) r = 0;
      else if (r > lim) r = lim;
    end
    return r;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin : model
    int d, p, t, lim;
    bit r;
    int np[2];
    if (!rst_n) begin
      m_pos[0] <= X0;
      m_pos[1] <= Y0;
      for (int a = 0; a < 2; a++) begin
        m_prev[a]  <= 0;
        m_ticks[a] <= 0;
        m_rep[a]   <= 1'b0;
      end
      m_edge <= 1'b0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        if (a == 0) begin
          d   = int'(bus.rect_right) - int'(bus.rect_left);
          lim = LIM_X;
        end else begin
          d   = int'(bus.rect_down) - int'(bus.rect_up);
          lim = LIM_Y;
        end
        p = m_pos[a];
        t = m_ticks[a];
        r = m_rep[a];
        if (d == 0) begin
          t = 0;
          r = 1'b0;
        end else if (d != m_prev[a]) begin
          p = mv(p, d, lim);
          t = 0;
          r = 1'b0;
        end else if (bus.frame_tick) begin
          t++;
          if (t == (r ? PER_FR : DLY_FR)) begin
            p = mv(p, d, lim);
            t = 0;
            r = 1'b1;
          end
        end
        np[a]      = p;
        m_pos[a]   <= p;
        m_ticks[a] <= t;
        m_rep[a]   <= r;
        m_prev[a]  <= d;
      end
      m_edge <= !WRAP && (np[0] == 0 || np[0] == LIM_X || np[1] == 0 || np[1] == LIM_Y);
    end
  end

  // Compare DUT against the model shortly after every active edge
  always @(posedge clk_in) begin
    #1;
    if (chk_en) begin
      check("xpos", int'(bus.xpos), m_pos[0]);
      check("ypos", int'(bus.ypos), m_pos[1]);
      check("at_edge", int'(bus.at_edge), int'(m_edge));
    end
  end

  task automatic cyc(input bit ft);
    bus.frame_tick = ft;
    @(negedge clk_in);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      cyc(1'b1);
      repeat (7) cyc(1'b0);
    end
  endtask

  task automatic release_all();
    bus.rect_up    = 1'b0;
    bus.rect_down  = 1'b0;
    bus.rect_left  = 1'b0;
    bus.rect_right = 1'b0;
  endtask

  task automatic do_reset();
    release_all();
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic lit(input string nm, input int got_dut, input int got_mdl, input int exp);
    check({nm, "_dut"}, got_dut, exp);
    check({nm, "_model"}, got_mdl, exp);
  endtask

  initial begin
    release_all();
    bus.frame_tick = 1'b0;
    @(negedge clk_in);
    do_reset();
    chk_en = 1'b1;

    // Idle for 10 frames
    frames(10);
    lit("idle_x", int'(bus.xpos), m_pos[0], 488);
    lit("idle_y", int'(bus.ypos), m_pos[1], 352);
    lit("idle_edge", int'(bus.at_edge), int'(m_edge), 0);

    // Short press: one step, no repeats
    bus.rect_right = 1'b1;
    cyc(1'b0);
    lit("press_x", int'(bus.xpos), m_pos[0], 492);
    cyc(1'b0);
    cyc(1'b0);
    bus.rect_right = 1'b0;
    repeat (5) cyc(1'b0);
    lit("press_hold_x", int'(bus.xpos), m_pos[0], 492);

    // Hold 30 frames: press, tick 20, 24, 28
    do_reset();
    bus.rect_right = 1'b1;
    cyc(1'b0);
    frames(30);
    lit("repeat_x", int'(bus.xpos), m_pos[0], 504);
    release_all();
    cyc(1'b0);

    // Opposing buttons cancel, releasing one steps immediately
    do_reset();
    bus.rect_left  = 1'b1;
    bus.rect_right = 1'b1;
    frames(30);
    lit("both_x", int'(bus.xpos), m_pos[0], 488);
    bus.rect_right = 1'b0;
    cyc(1'b0);
    lit("left_after_both_x", int'(bus.xpos), m_pos[0], 484);
    release_all();
    cyc(1'b0);

    // Walk to the left limit by single presses
    do_reset();
    for (int i = 0; i < 121; i++) begin
      bus.rect_left = 1'b1;
      cyc(1'b0);
      bus.rect_left = 1'b0;
      cyc(1'b0);
    end
    lit("walk_x", int'(bus.xpos), m_pos[0], 4);
    bus.rect_left = 1'b1;
    cyc(1'b0);
    lit("edge1_x", int'(bus.xpos), m_pos[0], 0);
    lit("edge1_flag", int'(bus.at_edge), int'(m_edge), WRAP ? 0 : 1);
    bus.rect_left = 1'b0;
    cyc(1'b0);
    bus.rect_left = 1'b1;
    cyc(1'b0);
    lit("edge2_x", int'(bus.xpos), m_pos[0], WRAP ? 973 : 0);
    lit("edge2_flag", int'(bus.at_edge), int'(m_edge), WRAP ? 0 : 1);
    release_all();
    cyc(1'b0);

    // Reset during auto-repeat with the button still held
    do_reset();
    bus.rect_down = 1'b1;
    cyc(1'b0);
    frames(22);
    lit("rpt_y", int'(bus.ypos), m_pos[1], 360);
    rst_n = 1'b0;
    cyc(1'b0);
    lit("rst_y", int'(bus.ypos), m_pos[1], 352);
    lit("rst_edge", int'(bus.at_edge), int'(m_edge), 0);
    rst_n = 1'b1;
    cyc(1'b0);
    lit("post_rst_y", int'(bus.ypos), m_pos[1], 356);
    release_all();
    cyc(1'b0);

    // Randomized buttons, frame ticks and occasional resets
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(39) == 0) bus.rect_up    = ~bus.rect_up;
      if ($urandom_range(39) == 0) bus.rect_down  = ~bus.rect_down;
      if ($urandom_range(39) == 0) bus.rect_left  = ~bus.rect_left;
      if ($urandom_range(39) == 0) bus.rect_right = ~bus.rect_right;
      rst_n = ($urandom_range(1499) != 0);
      cyc($urandom_range(2) == 0);
    end
    rst_n = 1'b1;
    release_all();
    cyc(1'b0);
    cyc(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
